// File: rtl/wave_run_ctrl_if.sv
// Signal bundle between the RS232 command decoder side and the playback run-state
// sequencer. The decoder drives command levels; the sequencer drives the time base.
interface wave_run_ctrl_if #(
   parameter int BIT_NUM = 32
) ();

   // iPERIOD is qualified by iPERIOD_STB. The word must stay stable while the strobe is
   // high and until the sequencer samples it on the synchronised rising edge. All
   // command inputs and iTRIG are levels, and each one acts once per rising edge.
   logic               iCMD_ARM;
   logic               iCMD_TO_INIT;
   logic               iCMD_RESET_TIME;
   logic               iCMD_RESET_DEV;
   logic               iPERIOD_STB;
   logic [BIT_NUM-1:0] iPERIOD;
   logic               iTRIG;
   logic               iREPEAT;

   logic [BIT_NUM-1:0] oTIME;
   logic               oTICK;
   logic [1:0]         oSTATE;
   logic               oARMED;
   logic               oRUNNING;
   logic               oDONE;
   logic               oLOAD_INIT;
   logic               oWRAP;
   logic               oDEV_RST;
   logic [BIT_NUM-1:0] oPERIOD;

   modport master (
      output iCMD_ARM, iCMD_TO_INIT, iCMD_RESET_TIME, iCMD_RESET_DEV,
      output iPERIOD_STB, iPERIOD, iTRIG, iREPEAT,
      input  oTIME, oTICK, oSTATE, oARMED, oRUNNING, oDONE,
      input  oLOAD_INIT, oWRAP, oDEV_RST, oPERIOD
   );

   modport slave (
      input  iCMD_ARM, iCMD_TO_INIT, iCMD_RESET_TIME, iCMD_RESET_DEV,
      input  iPERIOD_STB, iPERIOD, iTRIG, iREPEAT,
      output oTIME, oTICK, oSTATE, oARMED, oRUNNING, oDONE,
      output oLOAD_INIT, oWRAP, oDEV_RST, oPERIOD
   );

endinterface

// File: rtl/wave_run_ctrl.sv
// Playback run-state sequencer: resynchronises decoder commands and owns the global
// time base (arm, trigger, prescaled counting, wrap/stop, return-to-init, soft reset).
module wave_run_ctrl #(
   parameter int BIT_NUM     = 32,
   parameter int PRESCALE    = 50,
   parameter int SYNC_STAGES = 2
) (
   input  logic           iCLK,
   input  logic           iNRST,
   wave_run_ctrl_if.slave bus
);

   localparam int NEDGE     = 6;
   localparam int IDX_ARM   = 0;
   localparam int IDX_INIT  = 1;
   localparam int IDX_RTIME = 2;
   localparam int IDX_RDEV  = 3;
   localparam int IDX_STB   = 4;
   localparam int IDX_TRIG  = 5;
   localparam int IDX_REP   = 6;
   localparam int PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } runStateT;

   logic [NEDGE:0]     asyncIn;
   logic [NEDGE:0]     syncQ [SYNC_STAGES];
   logic [NEDGE:0]     syncLast;
   logic [NEDGE-1:0]   prevQ;
   logic [NEDGE-1:0]   rise;
   logic               repeatS;

   runStateT           stateQ, stateD;
   logic [BIT_NUM-1:0] timeQ, timeD;
   logic [BIT_NUM-1:0] periodQ, periodD;
   logic [BIT_NUM-1:0] pendQ, pendD;
   logic [PS_W-1:0]    prescQ, prescD;
   logic               tickQ, tickD;
   logic               wrapQ, wrapD;
   logic               loadInitQ, loadInitD;
   logic               devRstQ, devRstD;
   logic               lastPresc;
   logic               endOfPeriod;

   assign asyncIn = {bus.iREPEAT, bus.iTRIG, bus.iPERIOD_STB, bus.iCMD_RESET_DEV,
                     bus.iCMD_RESET_TIME, bus.iCMD_TO_INIT, bus.iCMD_ARM};

   // The synchroniser and edge history survive a soft device reset so that a command
   // level still held high after RESET_DEV cannot fire a second time.
   always_ff @(posedge iCLK or negedge iNRST) begin
      if (!iNRST) begin
         for (int i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
         prevQ <= '0;
      end else begin
         syncQ[0] <= asyncIn;
         for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
         prevQ <= syncLast[NEDGE-1:0];
      end
   end

   assign syncLast = syncQ[SYNC_STAGES-1];
   assign rise     = syncLast[NEDGE-1:0] & ~prevQ;
   assign repeatS  = syncLast[IDX_REP];

   assign lastPresc   = (prescQ == PS_LAST);
   assign endOfPeriod = (periodQ != '0) && (timeQ == periodQ - BIT_NUM'(1));

   always_ff @(posedge iCLK or negedge iNRST) begin
      if (!iNRST) stateQ <= IDLE;
      else        stateQ <= stateD;
   end

   always_ff @(posedge iCLK or negedge iNRST) begin
      if (!iNRST) begin
         timeQ     <= '0;
         periodQ   <= '0;
         pendQ     <= '0;
         prescQ    <= '0;
         tickQ     <= 1'b0;
         wrapQ     <= 1'b0;
         loadInitQ <= 1'b0;
         devRstQ   <= 1'b0;
      end else begin
         timeQ     <= timeD;
         periodQ   <= periodD;
         pendQ     <= pendD;
         prescQ    <= prescD;
         tickQ     <= tickD;
         wrapQ     <= wrapD;
         loadInitQ <= loadInitD;
         devRstQ   <= devRstD;
      end
   end

   always_comb begin
      stateD    = stateQ;
      timeD     = timeQ;
      periodD   = periodQ;
      pendD     = pendQ;
      prescD    = prescQ;
      tickD     = 1'b0;
      wrapD     = 1'b0;
      loadInitD = 1'b0;
      devRstD   = 1'b0;

      // A new period goes live at once unless it would disturb a period in progress.
      if (rise[IDX_STB]) begin
         pendD = bus.iPERIOD;
         if (stateQ != RUN) periodD = bus.iPERIOD;
      end

      if (rise[IDX_RDEV]) begin
         stateD  = IDLE;
         timeD   = '0;
         periodD = '0;
         pendD   = '0;
         prescD  = '0;
         devRstD = 1'b1;
      end else if (rise[IDX_INIT]) begin
         stateD    = IDLE;
         timeD     = '0;
         prescD    = '0;
         loadInitD = 1'b1;
      end else if (rise[IDX_RTIME]) begin
         timeD  = '0;
         prescD = '0;
      end else if (rise[IDX_ARM] && (stateQ == IDLE || stateQ == DONE)) begin
         stateD = ARMED;
         timeD  = '0;
         prescD = '0;
      end else if (rise[IDX_TRIG] && stateQ == ARMED) begin
         stateD  = RUN;
         timeD   = '0;
         prescD  = '0;
         periodD = pendD;
      end else begin
         case (stateQ)
            IDLE, ARMED: begin
               timeD  = '0;
               prescD = '0;
            end
            RUN: begin
               if (!lastPresc) begin
                  prescD = prescQ + PS_W'(1);
               end else begin
                  prescD = '0;
                  if (endOfPeriod) begin
                     if (repeatS) begin
                        timeD   = '0;
                        tickD   = 1'b1;
                        wrapD   = 1'b1;
                        periodD = pendD;
                     end else begin
                        stateD = DONE;
                     end
                  end else begin
                     // Free-run (period 0) rolls over naturally; flag that rollover.
                     timeD = timeQ + BIT_NUM'(1);
                     tickD = 1'b1;
                     wrapD = (timeQ == '1);
                  end
               end
            end
            default: begin
               prescD = '0;
            end
         endcase
      end
   end

   assign bus.oTIME      = timeQ;
   assign bus.oTICK      = tickQ;
   assign bus.oSTATE     = stateQ;
   assign bus.oARMED     = (stateQ == ARMED);
   assign bus.oRUNNING   = (stateQ == RUN);
   assign bus.oDONE      = (stateQ == DONE);
   assign bus.oLOAD_INIT = loadInitQ;
   assign bus.oWRAP      = wrapQ;
   assign bus.oDEV_RST   = devRstQ;
   assign bus.oPERIOD    = periodQ;

endmodule

// File: tb/tb_wave_run_ctrl.sv
// Bench for wave_run_ctrl: directed scenarios plus random command traffic, checked each
// cycle against a behavioural model of the run-state rules.
module tb_wave_run_ctrl;

   localparam int BW = 8;
   localparam int PS = 50;
   localparam int SS = 2;
   localparam int HD = SS + 2;

   localparam int B_ARM   = 0;
   localparam int B_INIT  = 1;
   localparam int B_RTIME = 2;
   localparam int B_RDEV  = 3;
   localparam int B_STB   = 4;
   localparam int B_TRIG  = 5;
   localparam int B_REP   = 6;

   logic iCLK  = 1'b0;
   logic iNRST = 1'b0;

   wave_run_ctrl_if #(.BIT_NUM(BW)) bus ();

   wave_run_ctrl #(
      .BIT_NUM(BW),
      .PRESCALE(PS),
      .SYNC_STAGES(SS)
   ) dut (
      .iCLK(iCLK),
      .iNRST(iNRST),
      .bus(bus.slave)
   );

   always #10 iCLK = ~iCLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model of the sequencer, advanced once per clock
   int          mState;
   logic [BW-1:0] mTime, mPeriod, mPend;
   int          mPhase;
   logic        mTick, mWrap, mLoad, mDev;
   logic [6:0]  hist [HD];

   // observations taken from the DUT
   int tickCnt, wrapCnt, loadCnt, devCnt, armEntries, prevState, lastWrapCyc;
   logic [BW-1:0] tickSeq[$];
   logic [BW-1:0] exp_q[$];

   task automatic model_reset();
      mState  = 0;
      mTime   = '0;
      mPeriod = '0;
      mPend   = '0;
      mPhase  = 0;
   endtask

   always @(posedge iCLK) begin
      logic [6:0] lvl, r;
      int nxt;
      cyc++;
      mTick = 1'b0; mWrap = 1'b0; mLoad = 1'b0; mDev = 1'b0;
      if (!iNRST) begin
         model_reset();
         for (int i = 0; i < HD; i++) hist[i] = '0;
      end else begin
         for (int i = HD - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = {bus.iREPEAT, bus.iTRIG, bus.iPERIOD_STB, bus.iCMD_RESET_DEV,
                    bus.iCMD_RESET_TIME, bus.iCMD_TO_INIT, bus.iCMD_ARM};
         // each input is seen SS clocks late; an edge is a 0 -> 1 step in that late view
         lvl = hist[SS];
         r   = hist[SS] & ~hist[SS+1];
         if (r[B_STB]) begin
            mPend = bus.iPERIOD;
            if (mState != 2) mPeriod = bus.iPERIOD;
         end
         if (r[B_RDEV]) begin
            model_reset();
            mDev = 1'b1;
         end else if (r[B_INIT]) begin
            mState = 0; mTime = '0; mPhase = 0; mLoad = 1'b1;
         end else if (r[B_RTIME]) begin
            mTime = '0; mPhase = 0;
         end else if (r[B_ARM] && (mState == 0 || mState == 3)) begin
            mState = 1; mTime = '0; mPhase = 0;
         end else if (r[B_TRIG] && mState == 1) begin
            mState = 2; mTime = '0; mPhase = 0; mPeriod = mPend;
         end else if (mState == 2) begin
            mPhase++;
            if (mPhase == PS) begin
               mPhase = 0;
               if (mPeriod != 0 && int'(mTime) + 1 == int'(mPeriod)) begin
                  if (lvl[B_REP]) begin
                     mTime = '0; mTick = 1'b1; mWrap = 1'b1; mPeriod = mPend;
                  end else begin
                     mState = 3;
                  end
               end else begin
                  nxt   = (int'(mTime) + 1) % (1 << BW);
                  mWrap = (nxt == 0);
                  mTime = BW'(nxt);
                  mTick = 1'b1;
               end
            end
         end
      end
   end

   always @(posedge iCLK) begin
      #1;
      if (iNRST) begin
         checks++;
         if (bus.oSTATE !== 2'(mState) || bus.oTIME !== mTime || bus.oPERIOD !== mPeriod ||
             bus.oTICK !== mTick || bus.oWRAP !== mWrap || bus.oLOAD_INIT !== mLoad ||
             bus.oDEV_RST !== mDev || bus.oARMED !== (mState == 1) ||
             bus.oRUNNING !== (mState == 2) || bus.oDONE !== (mState == 3)) begin
            errors++;
            $display("FAIL cycle_compare at cycle %0d: got st=%0d t=%0d p=%0d tk=%b wr=%b li=%b dr=%b dec=%b%b%b, want st=%0d t=%0d p=%0d tk=%b wr=%b li=%b dr=%b",
                     cyc, bus.oSTATE, bus.oTIME, bus.oPERIOD, bus.oTICK, bus.oWRAP,
                     bus.oLOAD_INIT, bus.oDEV_RST, bus.oARMED, bus.oRUNNING, bus.oDONE,
                     mState, mTime, mPeriod, mTick, mWrap, mLoad, mDev);
         end
         if (bus.oTICK) begin
            tickCnt++;
            tickSeq.push_back(bus.oTIME);
         end
         if (bus.oWRAP) begin
            wrapCnt++;
            lastWrapCyc = cyc;
         end
         if (bus.oLOAD_INIT) loadCnt++;
         if (bus.oDEV_RST) devCnt++;
         if (bus.oSTATE == 2'd1 && prevState != 1) armEntries++;
         prevState = int'(bus.oSTATE);
      end
   end

   task automatic expect_eq(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic check_seq(string name);
      expect_eq({name, "_len"}, tickSeq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < tickSeq.size(); i++)
         expect_eq($sformatf("%s_%0d", name, i), int'(tickSeq[i]), int'(exp_q[i]));
   endtask

   task automatic clear_obs();
      tickCnt = 0; wrapCnt = 0; loadCnt = 0; devCnt = 0; armEntries = 0;
      tickSeq.delete();
   endtask

   task automatic set_bit(int b, logic v);
      case (b)
         B_ARM:   bus.iCMD_ARM        = v;
         B_INIT:  bus.iCMD_TO_INIT    = v;
         B_RTIME: bus.iCMD_RESET_TIME = v;
         B_RDEV:  bus.iCMD_RESET_DEV  = v;
         B_STB:   bus.iPERIOD_STB     = v;
         B_TRIG:  bus.iTRIG           = v;
         default: bus.iREPEAT         = v;
      endcase
   endtask

   task automatic pulse(int b, int hold);
      @(negedge iCLK);
      set_bit(b, 1'b1);
      repeat (hold) @(negedge iCLK);
      set_bit(b, 1'b0);
      repeat (4) @(negedge iCLK);
   endtask

   task automatic strobe_period(int v);
      @(negedge iCLK);
      bus.iPERIOD = BW'(v);
      pulse(B_STB, 2);
   endtask

   task automatic wait_state(int s, int limit);
      int n = 0;
      while (int'(bus.oSTATE) != s && n < limit) begin
         @(negedge iCLK);
         n++;
      end
      expect_eq($sformatf("wait_state_%0d", s), int'(bus.oSTATE), s);
   endtask

   task automatic wait_time(int t, int limit);
      int n = 0;
      while (int'(bus.oTIME) != t && n < limit) begin
         @(negedge iCLK);
         n++;
      end
      expect_eq($sformatf("wait_time_%0d", t), int'(bus.oTIME), t);
   endtask

   task automatic wait_ticks(int k, int limit);
      int n = 0;
      while (tickCnt < k && n < limit) begin
         @(negedge iCLK);
         n++;
      end
      expect_eq("wait_ticks", (tickCnt >= k) ? 1 : 0, 1);
   endtask

   task automatic wait_wraps(int k, int limit);
      int n = 0;
      while (wrapCnt < k && n < limit) begin
         @(negedge iCLK);
         n++;
      end
      expect_eq("wait_wraps", (wrapCnt >= k) ? 1 : 0, 1);
   endtask

   task automatic start_run(output int c0);
      pulse(B_ARM, 2);
      wait_state(1, 20);
      @(negedge iCLK);
      set_bit(B_TRIG, 1'b1);
      wait_state(2, 20);
      c0 = cyc;
      clear_obs();
      @(negedge iCLK);
      set_bit(B_TRIG, 1'b0);
   endtask

   initial begin
      int c0;
      bus.iCMD_ARM = 1'b0; bus.iCMD_TO_INIT = 1'b0; bus.iCMD_RESET_TIME = 1'b0;
      bus.iCMD_RESET_DEV = 1'b0; bus.iPERIOD_STB = 1'b0; bus.iPERIOD = '0;
      bus.iTRIG = 1'b0; bus.iREPEAT = 1'b0;
      clear_obs();
      prevState = 0;
      lastWrapCyc = 0;

      // reset values
      repeat (3) @(negedge iCLK);
      expect_eq("rst_state", int'(bus.oSTATE), 0);
      expect_eq("rst_time", int'(bus.oTIME), 0);
      expect_eq("rst_period", int'(bus.oPERIOD), 0);
      expect_eq("rst_pulses", int'({bus.oTICK, bus.oWRAP, bus.oLOAD_INIT, bus.oDEV_RST}), 0);
      iNRST = 1'b1;
      repeat (5) @(negedge iCLK);

      // period 5, no repeat: 0..4 then DONE on the 5th tick
      strobe_period(5);
      expect_eq("stb_idle_period", int'(bus.oPERIOD), 5);
      start_run(c0);
      wait_state(3, 400);
      expect_eq("norep_done_cycles", cyc - c0, 250);
      expect_eq("norep_done_time", int'(bus.oTIME), 4);
      expect_eq("norep_ticks", tickCnt, 4);
      expect_eq("norep_wraps", wrapCnt, 0);
      exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
      check_seq("norep_seq");

      // period 5, repeat: 0,1,2,3,4,0,1
      pulse(B_INIT, 2);
      @(negedge iCLK);
      bus.iREPEAT = 1'b1;
      repeat (5) @(negedge iCLK);
      start_run(c0);
      wait_ticks(6, 400);
      expect_eq("rep_wraps", wrapCnt, 1);
      expect_eq("rep_wrap_cycle", lastWrapCyc - c0, 250);
      exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1};
      check_seq("rep_seq");

      // new period during RUN waits for the wrap
      wait_time(2, 100);
      strobe_period(3);
      expect_eq("pend_held_period", int'(bus.oPERIOD), 5);
      clear_obs();
      wait_wraps(1, 200);
      expect_eq("pend_applied_period", int'(bus.oPERIOD), 3);
      expect_eq("pend_applied_time", int'(bus.oTIME), 0);
      wait_ticks(6, 300);
      exp_q = '{8'd3, 8'd4, 8'd0, 8'd1, 8'd2, 8'd0};
      check_seq("pend_seq");
      expect_eq("pend_wraps", wrapCnt, 2);

      // TO_INIT and RESET_TIME together in RUN
      clear_obs();
      @(negedge iCLK);
      set_bit(B_INIT, 1'b1);
      set_bit(B_RTIME, 1'b1);
      repeat (3) @(negedge iCLK);
      set_bit(B_INIT, 1'b0);
      set_bit(B_RTIME, 1'b0);
      repeat (4) @(negedge iCLK);
      expect_eq("init_state", int'(bus.oSTATE), 0);
      expect_eq("init_time", int'(bus.oTIME), 0);
      expect_eq("init_loads", loadCnt, 1);
      expect_eq("init_period", int'(bus.oPERIOD), 3);

      // TRIG in IDLE ignored; ARM held long arms only once
      pulse(B_TRIG, 2);
      expect_eq("idle_trig_state", int'(bus.oSTATE), 0);
      clear_obs();
      @(negedge iCLK);
      set_bit(B_ARM, 1'b1);
      repeat (1000) @(negedge iCLK);
      set_bit(B_ARM, 1'b0);
      repeat (5) @(negedge iCLK);
      expect_eq("arm_held_entries", armEntries, 1);
      expect_eq("arm_held_state", int'(bus.oSTATE), 1);

      // RESET_DEV at oTIME=7
      strobe_period(10);
      expect_eq("armed_stb_period", int'(bus.oPERIOD), 10);
      @(negedge iCLK);
      set_bit(B_TRIG, 1'b1);
      wait_state(2, 20);
      set_bit(B_TRIG, 1'b0);
      wait_time(7, 500);
      clear_obs();
      pulse(B_RDEV, 1);
      expect_eq("rdev_state", int'(bus.oSTATE), 0);
      expect_eq("rdev_time", int'(bus.oTIME), 0);
      expect_eq("rdev_period", int'(bus.oPERIOD), 0);
      expect_eq("rdev_pulses", devCnt, 1);

      // period 1, repeat then no repeat
      strobe_period(1);
      start_run(c0);
      wait_ticks(4, 300);
      expect_eq("p1_rep_wraps", wrapCnt, 4);
      expect_eq("p1_rep_time", int'(bus.oTIME), 0);
      pulse(B_INIT, 2);
      @(negedge iCLK);
      bus.iREPEAT = 1'b0;
      repeat (5) @(negedge iCLK);
      start_run(c0);
      wait_state(3, 100);
      expect_eq("p1_norep_time", int'(bus.oTIME), 0);
      expect_eq("p1_norep_ticks", tickCnt, 0);
      expect_eq("p1_norep_cycles", cyc - c0, 50);

      // period 0: free-run rollover
      pulse(B_RDEV, 1);
      start_run(c0);
      wait_wraps(1, 13000);
      expect_eq("free_wrap_time", int'(bus.oTIME), 0);
      expect_eq("free_wrap_ticks", tickCnt, 256);
      expect_eq("free_wrap_cycle", lastWrapCyc - c0, 256 * PS);

      // iNRST mid-RUN: reset values, no oDEV_RST
      pulse(B_INIT, 2);
      strobe_period(9);
      start_run(c0);
      repeat (120) @(negedge iCLK);
      clear_obs();
      iNRST = 1'b0;
      #1;
      expect_eq("nrst_state", int'(bus.oSTATE), 0);
      expect_eq("nrst_time", int'(bus.oTIME), 0);
      expect_eq("nrst_period", int'(bus.oPERIOD), 0);
      expect_eq("nrst_devrst", int'(bus.oDEV_RST), 0);
      repeat (3) @(negedge iCLK);
      iNRST = 1'b1;
      repeat (5) @(negedge iCLK);
      expect_eq("nrst_dev_pulses", devCnt, 0);

      // random command traffic against the model
      for (int it = 0; it < 250; it++) begin
         int sel, hold;
         sel  = $urandom_range(0, 19);
         hold = $urandom_range(1, 4);
         if (sel < 4)       pulse(B_ARM, hold);
         else if (sel < 8)  pulse(B_TRIG, hold);
         else if (sel < 10) pulse(B_INIT, hold);
         else if (sel < 12) pulse(B_RTIME, hold);
         else if (sel < 13) pulse(B_RDEV, hold);
         else if (sel < 16) strobe_period($urandom_range(0, 4));
         else if (sel < 17) begin
            @(negedge iCLK);
            bus.iREPEAT = ~bus.iREPEAT;
         end else if (sel < 18) begin
            @(negedge iCLK);
            set_bit(B_ARM, 1'b1);
            set_bit(B_TRIG, 1'b1);
            repeat (hold) @(negedge iCLK);
            set_bit(B_ARM, 1'b0);
            set_bit(B_TRIG, 1'b0);
         end else begin
            repeat ($urandom_range(10, 150)) @(negedge iCLK);
         end
      end
      repeat (10) @(negedge iCLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #(200000 * 20);
      errors++;
      $display("FAIL watchdog: got timeout, want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
